// File: rtl/freq_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : freq_seg_display
//  Description : Snapshots the six BCD digits produced by the frequency
//                measurement stage once per 0.5 Hz gate period and scans
//                them onto an 8-digit seven-segment display. The display
//                uses leading-zero blanking, shows an invalid-digit dash, and
//                keeps all anodes off for a short guard interval at the start
//                of every digit slot to prevent ghosting.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_seg_display #(
  parameter int SCAN_DIV = 100000,  // clk100 cycles per digit slot
  parameter int GUARD    = 16       // all-anodes-off cycles at slot start
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       clk05Hz,
  input  logic [3:0] fre_num_u,
  input  logic [3:0] fre_num_d,
  input  logic [3:0] fre_num_h,
  input  logic [3:0] fre_num_t,
  input  logic [3:0] fre_num_m,
  input  logic [3:0] fre_num_l,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       snap
);

  localparam int              c_CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(SCAN_DIV - 1);
  localparam logic [c_CW-1:0] c_GUARD    = c_CW'(GUARD);
  localparam logic [7:0]      c_SEG_F    = 8'h71;
  localparam logic [7:0]      c_SEG_DASH = 8'h40;
  localparam logic [7:0]      c_SEG_OFF  = 8'h00;

  logic            r_c1;
  logic            r_c2;
  logic            w_rise;
  logic [3:0]      r_shadow [6];
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [5:0]      w_blank;
  logic [7:0]      w_seg_next;
  logic [7:0]      w_an_next;

  // Segment pattern for one BCD value; anything above 9 is shown as a dash.
  function automatic logic [7:0] f_decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = c_SEG_DASH;
    endcase
    return s;
  endfunction

  assign w_rise = r_c1 & ~r_c2;

  // Two-flop synchroniser on the gate clock; its delayed copy gives the rise.
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_c1 <= 1'b0;
      r_c2 <= 1'b0;
    end else begin
      r_c1 <= clk05Hz;
      r_c2 <= r_c1;
    end
  end

  // Capture a fresh digit set on each gate rise and flag it with snap.
  always_ff @(posedge clk100) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) r_shadow[k] <= 4'd0;
      snap <= 1'b0;
    end else begin
      snap <= w_rise;
      if (w_rise) begin
        r_shadow[0] <= fre_num_u;
        r_shadow[1] <= fre_num_d;
        r_shadow[2] <= fre_num_h;
        r_shadow[3] <= fre_num_t;
        r_shadow[4] <= fre_num_m;
        r_shadow[5] <= fre_num_l;
      end
    end
  end

  // Slot timer: after SCAN_DIV cycles move on to the next digit position.
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (r_cnt == c_CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Leading-zero blanking: a digit is blank when it and every more
  // significant digit are zero. Units are never blanked.
  always_comb begin
    logic v_all_zero;
    v_all_zero = 1'b1;
    w_blank    = 6'b000000;
    for (int k = 5; k >= 1; k--) begin
      v_all_zero = v_all_zero & (r_shadow[k] == 4'd0);
      w_blank[k] = v_all_zero;
    end
  end

  // Pick the pattern for the current slot: six digits, a blank and an 'F'.
  always_comb begin
    w_seg_next = c_SEG_OFF;
    case (r_idx)
      3'd0:    w_seg_next = f_decode(r_shadow[0]);
      3'd1:    w_seg_next = w_blank[1] ? c_SEG_OFF : f_decode(r_shadow[1]);
      3'd2:    w_seg_next = w_blank[2] ? c_SEG_OFF : f_decode(r_shadow[2]);
      3'd3:    w_seg_next = w_blank[3] ? c_SEG_OFF : f_decode(r_shadow[3]);
      3'd4:    w_seg_next = w_blank[4] ? c_SEG_OFF : f_decode(r_shadow[4]);
      3'd5:    w_seg_next = w_blank[5] ? c_SEG_OFF : f_decode(r_shadow[5]);
      3'd6:    w_seg_next = c_SEG_OFF;
      default: w_seg_next = c_SEG_F;
    endcase
  end

  // Anodes stay dark for the guard interval so the previous pattern fades.
  assign w_an_next = (r_cnt < c_GUARD) ? 8'h00 : (8'h01 << r_idx);

  // Registered display outputs, one cycle behind the slot timer.
  always_ff @(posedge clk100) begin
    if (rst) begin
      an  <= 8'h00;
      seg <= 8'h00;
    end else begin
      an  <= w_an_next;
      seg <= w_seg_next;
    end
  end

endmodule
`default_nettype wire
